// File: rtl/ascon_fsm.sv
// ascon_fsm: control sequencer stepping the ASCON-128 permutation_xor datapath
// through initialisation, associated data, plaintext and finalisation.
// Optional feature: define ASCON_FSM_ABORT_EN to add the abort_i input.
module ascon_fsm #(
    parameter int AD_BLOCKS = 1,
    parameter int PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
`ifdef ASCON_FSM_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       state_mode_o,
    output logic       en_reg_state_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_lsb_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_data_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
    } state_t;

    localparam logic [3:0] AD_LAST = 4'(AD_BLOCKS - 1);
    localparam logic [3:0] PT_LAST = 4'(PT_BLOCKS - 1);

    state_t     r_state, w_state_n;
    logic [3:0] r_round, w_round_n, w_round_inc;
    logic [3:0] r_blk, w_blk_n;
    logic       w_r11, w_ad_last, w_is_pt, w_fin, w_abort;

`ifdef ASCON_FSM_ABORT_EN
    assign w_abort = abort_i && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif
    assign w_r11       = r_round == 4'd11;
    assign w_round_inc = w_r11 ? 4'd0 : r_round + 4'd1;
    assign w_ad_last   = r_blk == AD_LAST;
    assign w_is_pt     = r_state == S_WAIT_PT;
    // The last plaintext absorb also opens the finalisation with the key XOR at round 0
    assign w_fin       = w_is_pt && (r_blk == PT_LAST);
    assign busy_o      = r_state != S_IDLE;

    // State, round counter and block counter registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_blk   <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_round <= w_round_n;
            r_blk   <= w_blk_n;
        end
    end

    // Next-state, counter updates and datapath control decode
    always_comb begin
        w_state_n          = r_state;
        w_round_n          = r_round;
        w_blk_n            = r_blk;
        data_ready_o       = 1'b0;
        round_o            = 4'd0;
        state_mode_o       = 1'b0;
        en_reg_state_o     = 1'b0;
        en_xor_key_begin_o = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_xor_key_end_o   = 1'b0;
        en_xor_data_o      = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        done_o             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_n = S_INIT;
                    w_round_n = 4'd0;
                    w_blk_n   = 4'd0;
                end
            end
            S_INIT: begin
                round_o          = r_round;
                state_mode_o     = r_round != 4'd0;
                en_reg_state_o   = 1'b1;
                en_xor_key_end_o = w_r11;
                w_round_n        = w_round_inc;
                w_state_n        = w_r11 ? S_WAIT_AD : S_INIT;
            end
            S_WAIT_AD, S_WAIT_PT: begin
                round_o            = w_fin ? 4'd0 : 4'd6;
                state_mode_o       = 1'b1;
                data_ready_o       = 1'b1;
                en_xor_data_o      = 1'b1;
                en_reg_state_o     = data_valid_i;
                en_cipher_o        = w_is_pt;
                en_xor_key_begin_o = w_fin;
                if (data_valid_i) begin
                    w_state_n = w_fin ? S_FINAL : (w_is_pt ? S_PT : S_AD);
                    w_round_n = w_fin ? 4'd1 : 4'd7;
                end
            end
            S_AD: begin
                round_o        = r_round;
                state_mode_o   = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_lsb_o   = w_r11 && w_ad_last;
                w_round_n      = w_round_inc;
                if (w_r11) begin
                    w_state_n = w_ad_last ? S_WAIT_PT : S_WAIT_AD;
                    w_blk_n   = w_ad_last ? 4'd0 : r_blk + 4'd1;
                end
            end
            S_PT: begin
                round_o        = r_round;
                state_mode_o   = 1'b1;
                en_reg_state_o = 1'b1;
                w_round_n      = w_round_inc;
                if (w_r11) begin
                    w_state_n = S_WAIT_PT;
                    w_blk_n   = r_blk + 4'd1;
                end
            end
            S_FINAL: begin
                round_o          = r_round;
                state_mode_o     = 1'b1;
                en_reg_state_o   = 1'b1;
                en_xor_key_end_o = w_r11;
                en_tag_o         = w_r11;
                w_round_n        = w_round_inc;
                if (w_r11) begin
                    w_state_n = S_DONE;
                    w_blk_n   = 4'd0;
                end
            end
            S_DONE: begin
                done_o    = 1'b1;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_n          = S_IDLE;
            w_round_n          = 4'd0;
            w_blk_n            = 4'd0;
            data_ready_o       = 1'b0;
            round_o            = 4'd0;
            state_mode_o       = 1'b0;
            en_reg_state_o     = 1'b0;
            en_xor_key_begin_o = 1'b0;
            en_xor_lsb_o       = 1'b0;
            en_xor_key_end_o   = 1'b0;
            en_xor_data_o      = 1'b0;
            en_cipher_o        = 1'b0;
            en_tag_o           = 1'b0;
            done_o             = 1'b0;
        end
    end
endmodule

// File: tb/tb_ascon_fsm.sv
// tb_ascon_fsm: self-checking bench for ascon_fsm (table vectors, directed corner cases, random message model)
module tb_ascon_fsm;
    localparam int AD = 1;
    localparam int PT = 4;

    logic       clk, reset_i, start_i, data_valid_i, abort_i;
    logic       data_ready_o, state_mode_o, en_reg_state_o, en_xor_key_begin_o, en_xor_lsb_o;
    logic       en_xor_key_end_o, en_xor_data_o, en_cipher_o, en_tag_o, busy_o, done_o;
    logic [3:0] round_o;
    logic [13:0] w_out;

    int n_chk = 0, n_fail = 0;
    int cyc, waits, pt_waits, n_lsb, n_ci, n_done, n_tag, done_at;

    ascon_fsm #(.AD_BLOCKS(AD), .PT_BLOCKS(PT)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .data_valid_i(data_valid_i),
`ifdef ASCON_FSM_ABORT_EN
        .abort_i(abort_i),
`endif
        .data_ready_o(data_ready_o), .round_o(round_o), .state_mode_o(state_mode_o),
        .en_reg_state_o(en_reg_state_o), .en_xor_key_begin_o(en_xor_key_begin_o),
        .en_xor_lsb_o(en_xor_lsb_o), .en_xor_key_end_o(en_xor_key_end_o),
        .en_xor_data_o(en_xor_data_o), .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    assign w_out = {data_ready_o, round_o, state_mode_o, en_reg_state_o, en_xor_key_begin_o, en_xor_lsb_o,
                    en_xor_key_end_o, en_xor_data_o, en_cipher_o, en_tag_o, busy_o, done_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] pk(input logic rdy, input int rnd, input logic md, input logic rg,
                                       input logic kb, input logic ls, input logic ke, input logic xd,
                                       input logic ci, input logic tg, input logic bz, input logic dn);
        return {rdy, 4'(rnd), md, rg, kb, ls, ke, xd, ci, tg, bz, dn};
    endfunction

    task automatic chk(input string nm, input logic [13:0] e);
        n_chk++;
        if (w_out !== e) begin
            n_fail++;
            $display("FAIL %s: outputs %b, expected %b (t=%0t)", nm, w_out, e, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    // One message cycle: inputs already driven, sample after the falling edge, advance
    task automatic cyc_chk(input string nm, input logic [13:0] e);
        cyc++;
        #1;
        chk(nm, e);
        n_lsb  += int'(en_xor_lsb_o);
        n_ci   += int'(en_cipher_o);
        n_tag  += int'(en_tag_o);
        n_done += int'(done_o);
        if (done_o) done_at = cyc;
        @(negedge clk);
    endtask

    task automatic drv(input int mode);
        data_valid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        start_i      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Absorb cycle: waits while valid is low, then transfers
    task automatic absorb(input int mode, input logic is_pt, input logic fin, input logic bp);
        int   tries;
        logic v;
        tries = 0;
        do begin
            if (mode == 1) v = (tries >= 6) || ($urandom_range(0, 2) != 0);
            else if (bp) v = tries >= 5;
            else v = 1'b1;
            data_valid_i = v;
            start_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!v) begin
                waits++;
                if (is_pt) pt_waits++;
            end
            cyc_chk(is_pt ? "wait_pt" : "wait_ad", pk(1, fin ? 0 : 6, 1, v, fin, 0, 0, 1, is_pt, 0, 1, 0));
            tries++;
        end while (!v);
    endtask

    // Walk one whole message as the ASCON phase structure: 12 init rounds, AD blocks, PT blocks, final
    // mode 0: valid high, 1: random valid/start, 2: 5-cycle stall on PT block 2, 3: stray start in AD, 4: abort
    task automatic run_msg(input int mode);
        cyc = 0; waits = 0; pt_waits = 0; n_lsb = 0; n_ci = 0; n_done = 0; n_tag = 0; done_at = 0;
        start_i = 1'b1;
        data_valid_i = 1'b0;
        #1;
        chk("idle_start", '0);
        @(negedge clk);
        for (int r = 0; r < 12; r++) begin
            drv(mode);
            cyc_chk("init", pk(0, r, r != 0, 1, 0, 0, r == 11, 0, 0, 0, 1, 0));
        end
        for (int b = 0; b < AD; b++) begin
            absorb(mode, 1'b0, 1'b0, 1'b0);
            for (int r = 7; r < 12; r++) begin
                drv(mode);
                if (mode == 3 && r == 8) start_i = 1'b1;
                cyc_chk("ad", pk(0, r, 1, 1, 0, r == 11 && b == AD - 1, 0, 0, 0, 0, 1, 0));
            end
        end
        for (int b = 0; b < PT; b++) begin
            absorb(mode, 1'b1, b == PT - 1, mode == 2 && b == 1);
            if (b < PT - 1)
                for (int r = 7; r < 12; r++) begin
                    drv(mode);
                    cyc_chk("pt", pk(0, r, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
                end
        end
        for (int r = 1; r < 12; r++) begin
            drv(mode);
`ifdef ASCON_FSM_ABORT_EN
            if (mode == 4 && r == 5) begin
                abort_i = 1'b1;
                cyc_chk("abort", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                abort_i = 1'b0;
                start_i = 1'b0;
                cyc_chk("abort_idle", '0);
                chk_int("abort_no_done", n_done, 0);
                chk_int("abort_no_tag", n_tag, 0);
                return;
            end
`endif
            cyc_chk("final", pk(0, r, 1, 1, 0, 0, r == 11, 0, 0, r == 11, 1, 0));
        end
        drv(mode);
        cyc_chk("done", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        start_i = 1'b0;
        cyc_chk("back_idle", '0);
        chk_int("done_cycle", done_at, 12 + 6 * AD + 6 * (PT - 1) + 12 + 1 + waits);
        chk_int("done_count", n_done, 1);
        chk_int("lsb_count", n_lsb, 1);
        chk_int("tag_count", n_tag, 1);
        chk_int("cipher_count", n_ci, PT + pt_waits);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("reset_hold", '0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("reset_release", '0);
        @(negedge clk);
    endtask

    vec_t tbl[17];

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        data_valid_i = 1'b0;
        abort_i = 1'b0;
        tbl[0] = '{1'b0, 1'b0, '0};
        tbl[1] = '{1'b0, 1'b1, '0};
        tbl[2] = '{1'b1, 1'b0, '0};
        for (int r = 0; r < 12; r++)
            tbl[3 + r] = '{1'b0, 1'b0, pk(0, r, r != 0, 1, 0, 0, r == 11, 0, 0, 0, 1, 0)};
        tbl[15] = '{1'b0, 1'b0, pk(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
        tbl[16] = '{1'b0, 1'b1, pk(1, 6, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0)};

        #3;
        chk("power_on_reset", '0);
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            start_i = tbl[i].start;
            data_valid_i = tbl[i].valid;
            #1;
            chk($sformatf("vec%0d", i), tbl[i].exp);
            @(negedge clk);
        end
        do_reset();

        run_msg(0);
        run_msg(2);
        run_msg(3);
        repeat (6) run_msg(1);

        start_i = 1'b1;
        data_valid_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset", pk(0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_reset", '0);
        @(negedge clk);
        reset_i = 1'b0;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            n_done += int'(done_o);
            @(negedge clk);
        end
        chk_int("reset_no_done", n_done, 0);
        #1;
        chk("reset_idle", '0);
        @(negedge clk);

`ifdef ASCON_FSM_ABORT_EN
        run_msg(4);
        run_msg(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ascon_fsm.md
Name: ascon_fsm

Overview:
- Control sequencer for the ASCON-128 encryption datapath `permutation_xor`. It sits directly upstream of that datapath.
- Drives `round_i`, `state_mode_i`, `en_i` and the XOR enables that step the datapath through four phases: initialisation (p12), associated data (p6 per block), plaintext (p6 per block) and finalisation (p12 plus tag).
- Exposes a start pulse, a valid/ready handshake for 64-bit data blocks, and a done pulse.

Parameters:
- AD_BLOCKS, 1, number of 64-bit associated-data blocks per message (range 1..15).
- PT_BLOCKS, 4, number of 64-bit plaintext blocks per message (range 1..15).

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start of message; sampled in IDLE only.
- data_valid_i  in  1  upstream has the AD/PT block on the datapath `data_i`.
- data_ready_o  out  1  FSM is absorbing a block this cycle.
- round_o  out  4  round index to the datapath.
- state_mode_o  out  1  0 = load the init state, 1 = feedback.
- en_reg_state_o  out  1  state register enable.
- en_xor_key_begin_o  out  1  XOR key before the permutation round.
- en_xor_lsb_o  out  1  domain-separation XOR (LSB of x4).
- en_xor_key_end_o  out  1  XOR key after the permutation round.
- en_xor_data_o  out  1  XOR `data_i` into x0.
- en_cipher_o  out  1  cipher register capture.
- en_tag_o  out  1  tag register capture.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the tag is valid.

Behaviour:
- **Reset:** asynchronous to IDLE. All outputs are 0, including `round_o` = 0. Block counter is 0. Reset mid-message abandons the message; no `done_o` is issued.
- **Outputs:** every output is combinational from the state register, round counter and `data_valid_i`.
- **Round counter:** 4-bit register, increments by 1 in RUN states and never exceeds 11.
- **IDLE:**
  - All enables are 0.
  - `start_i` = 1 → INIT with round = 0.
- **INIT:** 12 cycles, rounds 0..11.
  - Round 0: `state_mode_o` = 0. Rounds 1..11: `state_mode_o` = 1.
  - `en_reg_state_o` = 1 throughout.
  - Round 11: `en_xor_key_end_o` = 1.
  - After round 11 → WAIT_AD.
- **WAIT_AD (absorb cycle):**
  - Outputs: `round_o` = 6, `state_mode_o` = 1, `en_xor_data_o` = 1, `data_ready_o` = 1, `en_reg_state_o` = `data_valid_i`.
  - Transfer occurs when valid and ready are both high → AD with round = 7.
  - Without valid, the FSM stays in WAIT_AD and the state is frozen.
- **AD:** rounds 7..11, `en_reg_state_o` = 1.
  - Round 11 of the last AD block: `en_xor_lsb_o` = 1.
  - At round 11: block counter increments. Next state is WAIT_AD if more AD blocks remain, otherwise WAIT_PT (counter cleared).
- **WAIT_PT:** same as WAIT_AD, plus `en_cipher_o` = 1.
  - Non-last block: `round_o` = 6 → PT with round = 7.
  - Last block (counter = PT_BLOCKS-1): `round_o` = 0 and `en_xor_key_begin_o` = 1 → FINAL with round = 1.
- **PT:** rounds 7..11, `en_reg_state_o` = 1.
  - At round 11: block counter increments → WAIT_PT.
- **FINAL:** rounds 1..11, `en_reg_state_o` = 1.
  - Round 11: `en_xor_key_end_o` = 1 and `en_tag_o` = 1.
  - After round 11 → DONE.
- **DONE:** 1 cycle, `done_o` = 1, all enables 0 → IDLE.
- **Ignored inputs:**
  - `start_i` outside IDLE.
  - `data_valid_i` outside the WAIT states.
- **Counter width:** block counter is 4 bits; terminal compare against PARAM-1.
- **Latency:** with `data_valid_i` held high, AD = 1 and PT = 4, `done_o` asserts in the 49th cycle after the edge that samples `start_i`. Breakdown: 12 INIT + 6 AD + 18 PT + 12 final.

Optional Feature:
- Macro: `ASCON_FSM_ABORT_EN`.
- **Defined:**
  - Adds input port `abort_i` (1 bit).
  - `abort_i` = 1 in any non-IDLE state forces all enables to 0 that cycle and sets next state to IDLE. Round and block counters clear.
  - No `done_o` is issued.
  - `abort_i` in IDLE has no effect.
  - `abort_i` has priority over `data_valid_i`.
- **Undefined:** port absent; the message always runs to DONE unless reset.

Test Plan:
- **Reset/IDLE:** `reset_i` = 1 asynchronously mid-cycle → all outputs 0 immediately. Release with `start_i` = 0 → outputs stay 0 and `busy_o` = 0.
- **INIT sequence:** `start_i` pulse → next 12 cycles `round_o` = 0..11. `state_mode_o` = 0 only at round 0. `en_xor_key_end_o` = 1 only at round 11. Then `data_ready_o` = 1 with `round_o` = 6.
- **Full message, valid always high:** AD = 1, PT = 4.
  - `en_xor_lsb_o` pulses once, at the end of the AD block.
  - `en_cipher_o` pulses exactly 4 times.
  - `en_xor_key_begin_o` coincides with the 4th `en_cipher_o`, at `round_o` = 0.
  - `en_tag_o` is one cycle before `done_o`; `done_o` is in cycle 49.
- **Backpressure:** hold `data_valid_i` = 0 for 5 cycles in WAIT_PT block 2 → `en_reg_state_o` = 0 and `round_o` stays 6 for those cycles. `done_o` slips to cycle 54.
- **Ignored start:** pulse `start_i` during AD rounds → sequence unchanged; exactly one `done_o`.
- **Abort (`ASCON_FSM_ABORT_EN`):** `abort_i` = 1 at FINAL round 5 → next cycle IDLE, `busy_o` = 0, `en_tag_o` and `done_o` never asserted. A fresh `start_i` then completes normally.
